fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- Instruction fetch plus IF/ID pipeline register for the 10-bit MIPS-FPGA datapath.
- Holds the PC and drives the instruction-memory address.
- Latches the 16-bit instruction and splits it into fields. The 6-bit immediate field feeds the sign-extension stage directly downstream.
- Supports stall, branch redirect with flush, a one-cycle boot bubble after reset, and a sticky halt.

Parameters:
- PC_W, 10, width of PC and branch target
- INSTR_W, 16, instruction width; field layout below assumes 16
- RESET_PC, 0, PC value loaded on reset
- HALT_OP, 4'hF, opcode that halts fetch

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_in  in  INSTR_W  instruction memory read data for address pc, combinational, valid in the same cycle
- stall  in  1  hold the PC and IR this cycle
- branch_taken  in  1  redirect fetch to branch_target and flush IR
- branch_target  in  PC_W  redirect address
- pc  out  PC_W  instruction memory address
- ir_valid  out  1  IR holds a real instruction
- opcode  out  4  IR[15:12]
- rs  out  3  IR[11:9]
- rt  out  3  IR[8:6]
- imm  out  6  IR[5:0], to the sign extender's 6-bit input
- pc_plus1  out  PC_W  address of the IR instruction +1, for the branch adder
- halted  out  1  high in HALT state

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, IR=0, ir_valid=0, pc_plus1=0, halted=0, state=BOOT.
  - Reset asserted mid-operation overrides everything with no delay.
- Field outputs are combinational slices of IR. IR is forced to 0 whenever ir_valid=0, so all fields read 0.
- FSM states: BOOT, RUN, HALT.
- BOOT:
  - First rising edge after rst deasserts: nothing is fetched; pc holds, ir_valid stays 0. This lets the memory present instr_in for pc.
  - Next state is RUN, regardless of stall or branch_taken (both ignored in BOOT).
- RUN: at each edge, actions in priority order:
  1. branch_taken=1:
     - pc<=branch_target; IR<=0; ir_valid<=0; pc_plus1 holds.
     - branch_taken wins over stall.
  2. stall=1: pc, IR, ir_valid and pc_plus1 all hold.
  3. Otherwise (normal fetch):
     - IR<=instr_in; ir_valid<=1; pc_plus1<=pc+1; pc<=pc+1.
     - All adds are modulo 2^PC_W, so 1023 wraps to 0.
     - If instr_in[15:12]==HALT_OP: the instruction is still latched (ir_valid<=1), pc is NOT incremented, and next state is HALT.
- HALT:
  - halted=1; pc, IR, ir_valid and pc_plus1 frozen.
  - stall and branch_taken are ignored.
  - Exits only through rst.
- Latency: an instruction presented on instr_in at the edge where pc=A appears in IR, with pc_plus1=A+1, one cycle later.
- Throughput: one instruction per cycle when no stall or branch.
- Redirect bubble: a branch inserts exactly one invalid IR cycle.
- Mutual exclusion: stall and branch_taken are never X-propagated into state. Undefined inputs during BOOT or HALT have no effect.

Test Plan:
- Reset then free run: rst pulse, instr_in=16'h1047 at every address -> edge1 BOOT (pc=0, ir_valid=0); edge2 pc=1, ir_valid=1, opcode=1, rs=0, rt=1, imm=6'b000111, pc_plus1=1; edge3 pc=2.
- Stall: in RUN at pc=5, stall=1 for 3 edges -> pc=5, IR and pc_plus1 unchanged for 3 cycles; after release pc=6 on the next edge.
- Branch with simultaneous stall: pc=7, branch_taken=1, stall=1, branch_target=10'h200 -> next cycle pc=10'h200, ir_valid=0, imm=0; the following edge latches instr_in with pc_plus1=10'h201.
- Wrap: branch to 10'h3FF, then normal fetch -> pc=0, pc_plus1=0.
- Halt: instr_in=16'hF02A at pc=3 -> IR=F02A, imm=6'b101010, pc stays 3, halted=1; asserting branch_taken or stall for 5 cycles changes nothing.
- Async reset mid-run: assert rst between edges at pc=9 -> pc=0, ir_valid=0, halted=0 immediately without a clock edge; after release, BOOT bubble repeats.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// Instruction fetch and IF/ID pipeline register for the 10-bit MIPS-FPGA datapath.
// Holds the PC, latches the fetched instruction and splits it into decode fields.
module fetch_decode_stage #(
    parameter int              PC_W     = 10,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    pc,
    output logic               ir_valid,
    output logic [3:0]         opcode,
    output logic [2:0]         rs,
    output logic [2:0]         rt,
    output logic [5:0]         imm,
    output logic [PC_W-1:0]    pc_plus1,
    output logic               halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_plus1_q, pc_plus1_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               ir_valid_q, ir_valid_d;
    logic [PC_W-1:0]    pc_inc;

    assign pc_inc = pc_q + PC_W'(1);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_plus1_d = pc_plus1_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        case (state_q)
            // One bubble so the instruction memory can present data for the reset PC.
            BOOT: state_d = RUN;
            RUN: begin
                if (branch_taken) begin
                    pc_d       = branch_target;
                    ir_d       = '0;
                    ir_valid_d = 1'b0;
                end else if (!stall) begin
                    ir_d       = instr_in;
                    ir_valid_d = 1'b1;
                    pc_plus1_d = pc_inc;
                    // A halt instruction is still latched, but fetch stops at its address.
                    if (instr_in[15:12] == HALT_OP) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            HALT:    state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pc_plus1_q <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_plus1_q <= pc_plus1_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign pc       = pc_q;
    assign pc_plus1 = pc_plus1_q;
    assign ir_valid = ir_valid_q;
    assign halted   = (state_q == HALT);
    assign opcode   = ir_q[15:12];
    assign rs       = ir_q[11:9];
    assign rt       = ir_q[8:6];
    assign imm      = ir_q[5:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage: directed scenarios followed by
// randomized stall/branch/reset traffic against a behavioural reference model.
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr_in;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [9:0]  branch_target = '0;
    logic [9:0]  pc;
    logic        ir_valid;
    logic [3:0]  opcode;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [5:0]  imm;
    logic [9:0]  pc_plus1;
    logic        halted;

    logic [15:0] mem [1024];

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state, kept as plain integers
    int m_pc, m_ir, m_pp1;
    bit m_valid, m_halt, m_boot;

    fetch_decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .instr_in      (instr_in),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .ir_valid      (ir_valid),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .imm           (imm),
        .pc_plus1      (pc_plus1),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory: combinational read at the current PC
    always_comb instr_in = mem[pc];

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_pc    = 0;
        m_ir    = 0;
        m_pp1   = 0;
        m_valid = 0;
        m_halt  = 0;
        m_boot  = 1;
    endtask

    task automatic modelEdge(input bit s, input bit b, input int tgt);
        int word;
        if (m_halt) return;
        if (m_boot) begin
            m_boot = 0;
            return;
        end
        if (b) begin
            m_pc    = tgt;
            m_ir    = 0;
            m_valid = 0;
        end else if (!s) begin
            word    = int'(mem[m_pc]);
            m_ir    = word;
            m_valid = 1;
            m_pp1   = (m_pc + 1) % 1024;
            if (word / 4096 == 15) m_halt = 1;
            else                   m_pc   = (m_pc + 1) % 1024;
        end
    endtask

    task automatic checkAll(input string where);
        checkOutput({where, ".pc"},       int'(pc),       m_pc);
        checkOutput({where, ".ir_valid"}, int'(ir_valid), int'(m_valid));
        checkOutput({where, ".opcode"},   int'(opcode),   (m_ir / 4096) % 16);
        checkOutput({where, ".rs"},       int'(rs),       (m_ir / 512) % 8);
        checkOutput({where, ".rt"},       int'(rt),       (m_ir / 64) % 8);
        checkOutput({where, ".imm"},      int'(imm),      m_ir % 64);
        checkOutput({where, ".pc_plus1"}, int'(pc_plus1), m_pp1);
        checkOutput({where, ".halted"},   int'(halted),   int'(m_halt));
    endtask

    // Drive inputs between edges, advance one clock, then compare against the model
    task automatic applyStimulus(input bit s, input bit b, input int tgt, input string where);
        stall         = s;
        branch_taken  = b;
        branch_target = 10'(tgt);
        @(posedge clk);
        modelEdge(s, b, tgt);
        #1;
        checkAll(where);
    endtask

    // Asserts reset between edges and checks the reset state before any clock edge
    task automatic asyncReset(input string where);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll(where);
        #1;
        rst = 1'b0;
    endtask

    task automatic fillMem(input logic [15:0] word);
        for (int i = 0; i < 1024; i++) mem[i] = word;
    endtask

    initial begin
        int guard;
        logic [15:0] w;
        fillMem(16'h1047);
        modelReset();

        // Reset then free run
        asyncReset("reset");
        applyStimulus(0, 0, 0, "boot");
        checkOutput("boot_hold_pc", int'(pc), 0);
        applyStimulus(0, 0, 0, "run1");
        checkOutput("first_imm", int'(imm), 7);
        checkOutput("first_pp1", int'(pc_plus1), 1);
        applyStimulus(0, 0, 0, "run2");
        checkOutput("second_pc", int'(pc), 2);

        // Advance to pc=5 and stall for three edges
        guard = 0;
        while (m_pc != 5 && guard < 20) begin
            applyStimulus(0, 0, 0, "to5");
            guard++;
        end
        checkOutput("reach_pc5", int'(pc), 5);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, "stall");
        applyStimulus(0, 0, 0, "unstall");
        checkOutput("after_stall_pc", int'(pc), 6);

        // Branch with simultaneous stall at pc=7
        applyStimulus(0, 0, 0, "to7");
        applyStimulus(1, 1, 'h200, "branch");
        checkOutput("branch_pc", int'(pc), 'h200);
        checkOutput("branch_bubble", int'(ir_valid), 0);
        applyStimulus(0, 0, 0, "after_branch");
        checkOutput("after_branch_pp1", int'(pc_plus1), 'h201);

        // Wrap at the top of the address space
        applyStimulus(0, 1, 'h3FF, "branch_top");
        applyStimulus(0, 0, 0, "wrap");
        checkOutput("wrap_pc", int'(pc), 0);
        checkOutput("wrap_pp1", int'(pc_plus1), 0);

        // Async reset mid-run at pc=9
        guard = 0;
        while (m_pc != 9 && guard < 20) begin
            applyStimulus(0, 0, 0, "to9");
            guard++;
        end
        asyncReset("midrun_reset");
        applyStimulus(0, 0, 0, "reboot");
        checkOutput("reboot_bubble", int'(ir_valid), 0);

        // Halt instruction at address 3
        mem[3] = 16'hF02A;
        asyncReset("halt_reset");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, "to_halt");
        checkOutput("halt_flag", int'(halted), 1);
        checkOutput("halt_pc", int'(pc), 3);
        checkOutput("halt_imm", int'(imm), 'h2A);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1023)), "halt_frozen");

        // Randomized traffic; halt opcodes kept rare so runs stay long
        for (int i = 0; i < 1024; i++) begin
            w = 16'($urandom_range(0, 65535));
            if (w[15:12] == 4'hF && $urandom_range(0, 15) != 0) w[15:12] = 4'h3;
            mem[i] = w;
        end
        asyncReset("rand_reset");
        guard = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_halt) guard++;
            if (guard > 6 || $urandom_range(0, 99) == 0) begin
                guard = 0;
                asyncReset("rand_async");
            end else begin
                applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
                              int'($urandom_range(0, 1023)), "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
